// File: rtl/utopia_pkg.sv
// -----------------------------------------------------------------------------
// utopia_pkg
// Shared definitions for the UTOPIA Level 1 ATM cell receive path.
//   rx_state_t    : receive framer states
//   CELL_* / *_W  : cell geometry and the width of one buffered cell record
//   HEC_*         : CRC-8 generator polynomial and coset
//   hec_calc()    : HEC over the four header bytes {b0,b1,b2,b3}
// -----------------------------------------------------------------------------
package utopia_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_HDR,
    RX_PAYLOAD,
    RX_WRITE
  } rx_state_t;

  localparam int CELL_BYTES    = 53;
  localparam int HDR_BYTES     = 5;
  localparam int PAYLOAD_BYTES = 48;

  localparam logic [7:0] HEC_POLY  = 8'h07;
  localparam logic [7:0] HEC_COSET = 8'h55;

  localparam int HDR_W      = HDR_BYTES * 8;
  localparam int PAYLOAD_W  = PAYLOAD_BYTES * 8;
  localparam int CELL_W     = CELL_BYTES * 8;
  // A buffered cell is the raw 53 bytes plus the HEC error flag on top.
  localparam int CELL_REC_W = CELL_W + 1;

  localparam logic [5:0] LAST_HDR_IDX  = 6'(HDR_BYTES - 1);
  localparam logic [5:0] LAST_CELL_IDX = 6'(CELL_BYTES - 1);

  // CRC-8 processed MSB first across b0..b3, seed zero, then coset added.
  function automatic logic [7:0] hec_calc(input logic [31:0] hdr);
    logic [7:0] crc;
    crc = '0;
    for (int i = 31; i >= 0; i--) begin
      if (crc[7] ^ hdr[i]) begin
        crc = {crc[6:0], 1'b0} ^ HEC_POLY;
      end else begin
        crc = {crc[6:0], 1'b0};
      end
    end
    return crc ^ HEC_COSET;
  endfunction

endpackage

// File: rtl/fifo_rx.sv
// -----------------------------------------------------------------------------
// fifo_rx
// Synchronous FIFO with first-word fall-through output.
//   clk, rst_n   : clock, synchronous active-low reset (empties the FIFO)
//   i_wr_en      : write request; honoured when not full or when popping
//   i_wr_data    : record to write
//   i_rd_en      : pop request; ignored when empty
//   o_rd_data    : head record, forced to zero while empty
//   o_full       : DEPTH records held
//   o_empty      : no records held
// -----------------------------------------------------------------------------
module fifo_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_rd;
  logic w_do_wr;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_do_rd = i_rd_en && !o_empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO is fine.
  assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

  // Gating the head with empty keeps the outputs at zero after reset
  // without having to clear the storage array.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/utopia1_atm_rx.sv
// -----------------------------------------------------------------------------
// utopia1_atm_rx
// UTOPIA Level 1 ATM cell receiver. Reassembles 53-byte cells from the byte
// stream, checks the HEC, and buffers complete cells for the core.
//   clk, rst_n          : clock, synchronous active-low reset
//   soc, data, en       : incoming cell stream (soc marks header byte 0)
//   clav                : registered cell-space-available to the sender
//   rxvalid, rxack      : head-cell valid / pop handshake
//   fifo_empty/full     : cell buffer status
//   rx_overflow         : pulse, complete cell dropped because buffer full
//   rx_runt             : pulse, partial cell aborted by a new soc
//   uni_*               : head-cell UNI header fields and payload
//   uni_hec_err         : head cell arrived with a bad HEC
// -----------------------------------------------------------------------------
module utopia1_atm_rx
  import utopia_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         soc,
  input  logic [7:0]   data,
  input  logic         en,
  output logic         clav,
  output logic         rxvalid,
  input  logic         rxack,
  output logic         fifo_empty,
  output logic         fifo_full,
  output logic         rx_overflow,
  output logic         rx_runt,
  output logic [3:0]   uni_GFC,
  output logic [7:0]   uni_VPI,
  output logic [15:0]  uni_VCI,
  output logic         uni_CLP,
  output logic [2:0]   uni_PT,
  output logic [7:0]   uni_HEC,
  output logic [383:0] uni_Payload,
  output logic         uni_hec_err
);

  rx_state_t            r_state;
  logic [5:0]           r_idx;
  logic [HDR_W-1:0]     r_hdr;
  logic [PAYLOAD_W-1:0] r_payload;
  logic                 r_clav;
  logic                 r_runt;
  logic                 r_overflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_en;
  logic                  w_wr_en;
  logic                  w_hec_err;
  logic [5:0]            w_pidx;
  logic [CELL_REC_W-1:0] w_wr_data;
  logic [CELL_REC_W-1:0] w_head;

  assign w_rd_en   = rxack && !w_empty;
  assign w_wr_en   = (r_state == RX_WRITE);
  assign w_pidx    = r_idx - 6'(HDR_BYTES);
  // r_hdr holds b0 in the top byte and b4 (received HEC) in the bottom byte.
  assign w_hec_err = (hec_calc(r_hdr[HDR_W-1:8]) != r_hdr[7:0]);
  assign w_wr_data = {w_hec_err, r_hdr, r_payload};

  fifo_rx #(
    .WIDTH (CELL_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_rd_en),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Framer: collects bytes into r_hdr/r_payload, spends one WRITE cycle
  // pushing the finished cell, and aborts on an unexpected soc.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= RX_IDLE;
      r_idx      <= '0;
      r_hdr      <= '0;
      r_payload  <= '0;
      r_clav     <= 1'b0;
      r_runt     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_runt     <= 1'b0;
      r_overflow <= 1'b0;
      r_clav     <= !w_full;
      case (r_state)
        RX_IDLE: begin
          if (en && soc) begin
            r_hdr[39:32] <= data;
            r_idx        <= 6'd1;
            r_state      <= RX_HDR;
          end
        end
        RX_HDR: begin
          if (en && soc) begin
            r_runt       <= 1'b1;
            r_hdr[39:32] <= data;
            r_idx        <= 6'd1;
          end else if (en) begin
            case (r_idx[2:0])
              3'd1:    r_hdr[31:24] <= data;
              3'd2:    r_hdr[23:16] <= data;
              3'd3:    r_hdr[15:8]  <= data;
              3'd4:    r_hdr[7:0]   <= data;
              default: r_hdr        <= r_hdr;
            endcase
            r_idx <= r_idx + 6'd1;
            if (r_idx == LAST_HDR_IDX) begin
              r_state <= RX_PAYLOAD;
            end
          end
        end
        RX_PAYLOAD: begin
          if (en && soc) begin
            r_runt       <= 1'b1;
            r_hdr[39:32] <= data;
            r_idx        <= 6'd1;
            r_state      <= RX_HDR;
          end else if (en) begin
            r_payload[{w_pidx, 3'b000} +: 8] <= data;
            // Index saturates on the last byte instead of running past 52.
            if (r_idx == LAST_CELL_IDX) begin
              r_state <= RX_WRITE;
            end else begin
              r_idx <= r_idx + 6'd1;
            end
          end
        end
        RX_WRITE: begin
          r_overflow <= w_full && !w_rd_en;
          if (en && soc) begin
            r_hdr[39:32] <= data;
            r_idx        <= 6'd1;
            r_state      <= RX_HDR;
          end else begin
            r_idx   <= '0;
            r_state <= RX_IDLE;
          end
        end
        default: begin
          r_idx   <= '0;
          r_state <= RX_IDLE;
        end
      endcase
    end
  end

  assign clav        = r_clav;
  assign rx_runt     = r_runt;
  assign rx_overflow = r_overflow;
  assign fifo_empty  = w_empty;
  assign fifo_full   = w_full;
  assign rxvalid     = !w_empty;

  // Unpack the head record: {hec_err, b0..b4, payload}.
  assign uni_hec_err = w_head[424];
  assign uni_GFC     = w_head[423:420];
  assign uni_VPI     = w_head[419:412];
  assign uni_VCI     = w_head[411:396];
  assign uni_CLP     = w_head[395];
  assign uni_PT      = w_head[394:392];
  assign uni_HEC     = w_head[391:384];
  assign uni_Payload = w_head[383:0];

endmodule
